// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and constants for the JTAG/SRAM arbiter
package jtag_pkg;

    localparam int JTAG_ADDR_W     = 18;
    localparam int JTAG_DATA_W     = 16;
    localparam int DEF_WE_CYCLES   = 2;
    localparam int DEF_TURN_CYCLES = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_GRANT = 3'd2,
        S_WR    = 3'd3,
        S_REC   = 3'd4,
        S_REL   = 3'd5
    } state_t;

    // 4-bit counters stop at 15 rather than wrapping
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/jtag_sram_arbiter_if.sv
// rtl/jtag_sram_arbiter_if.sv - JTAG, CPU and SRAM side signals of the arbiter
interface jtag_sram_arbiter_if;

    logic                             iHOLD;
    logic                             oHLDA;
    logic                             iCPU_IDLE;
    logic                             oCPU_STALL;
    logic [jtag_pkg::JTAG_ADDR_W-1:0] iJTAG_ADDR;
    logic [jtag_pkg::JTAG_DATA_W-1:0] iJTAG_DATA;
    logic                             iJTAG_WR_N;
    logic [jtag_pkg::JTAG_DATA_W-1:0] oJTAG_RDATA;
    logic [jtag_pkg::JTAG_ADDR_W-1:0] iCPU_ADDR;
    logic [jtag_pkg::JTAG_DATA_W-1:0] iCPU_DATA;
    logic                             iCPU_WR_N;
    logic [jtag_pkg::JTAG_ADDR_W-1:0] oSRAM_ADDR;
    logic [jtag_pkg::JTAG_DATA_W-1:0] oSRAM_DQ_OUT;
    logic                             oSRAM_DQ_OE;
    logic                             oSRAM_WE_N;
    logic [jtag_pkg::JTAG_DATA_W-1:0] iSRAM_DQ_IN;

    modport master (
        input  iHOLD, iCPU_IDLE, iJTAG_ADDR, iJTAG_DATA, iJTAG_WR_N,
               iCPU_ADDR, iCPU_DATA, iCPU_WR_N, iSRAM_DQ_IN,
        output oHLDA, oCPU_STALL, oJTAG_RDATA,
               oSRAM_ADDR, oSRAM_DQ_OUT, oSRAM_DQ_OE, oSRAM_WE_N
    );

    modport slave (
        output iHOLD, iCPU_IDLE, iJTAG_ADDR, iJTAG_DATA, iJTAG_WR_N,
               iCPU_ADDR, iCPU_DATA, iCPU_WR_N, iSRAM_DQ_IN,
        input  oHLDA, oCPU_STALL, oJTAG_RDATA,
               oSRAM_ADDR, oSRAM_DQ_OUT, oSRAM_DQ_OE, oSRAM_WE_N
    );

endinterface

// File: rtl/jtag_wr_strobe_gen.sv
// rtl/jtag_wr_strobe_gen.sv - JTAG write edge detect, one-deep pending slot and WE/OE pulse timing
module jtag_wr_strobe_gen import jtag_pkg::*; #(
    parameter int WE_CYCLES = DEF_WE_CYCLES
) (
    input  logic clk24,
    input  logic reset,
    input  logic wr_n,
    input  logic capture_en,
    input  logic start,
    output logic wr_edge,
    output logic pending,
    output logic overrun,
    output logic busy,
    output logic done,
    output logic we_n,
    output logic oe
);

    localparam logic [3:0] WE_CNT = 4'(WE_CYCLES);

    if (WE_CYCLES < 1 || WE_CYCLES > 15) begin : g_bad_we_cycles
        $error("jtag_wr_strobe_gen: WE_CYCLES must be in 1..15");
    end

    logic       wr_prev;
    logic       hold_ph;
    logic [3:0] cnt;

    assign wr_edge = wr_prev & ~wr_n;
    assign done    = busy & hold_ph;

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            wr_prev <= 1'b1;
            pending <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
            hold_ph <= 1'b0;
            we_n    <= 1'b1;
            oe      <= 1'b0;
            cnt     <= 4'd0;
        end else begin
            wr_prev <= wr_n;

            // a start consumes the slot; an edge landing on that same cycle refills it
            if (start) begin
                pending <= pending & wr_edge;
            end else if (capture_en && wr_edge) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end

            if (start) begin
                busy    <= 1'b1;
                hold_ph <= 1'b0;
                we_n    <= 1'b0;
                oe      <= 1'b1;
                cnt     <= 4'd1;
            end else if (busy) begin
                if (hold_ph) begin
                    busy    <= 1'b0;
                    hold_ph <= 1'b0;
                    oe      <= 1'b0;
                    cnt     <= 4'd0;
                end else if (cnt >= WE_CNT) begin
                    we_n    <= 1'b1;
                    hold_ph <= 1'b1;
                end else begin
                    cnt <= sat_inc(cnt);
                end
            end
        end
    end

endmodule

// File: rtl/jtag_sram_arbiter.sv
// rtl/jtag_sram_arbiter.sv - CPU hold/acknowledge handshake and SRAM bus mux for JTAG access
module jtag_sram_arbiter import jtag_pkg::*; #(
    parameter int WE_CYCLES   = DEF_WE_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                clk24,
    input  logic                reset,
    jtag_sram_arbiter_if.master bus
);

    localparam logic [3:0] TURN_CNT = 4'(TURN_CYCLES);

    if (TURN_CYCLES < 0 || TURN_CYCLES > 7) begin : g_bad_turn_cycles
        $error("jtag_sram_arbiter: TURN_CYCLES must be in 0..7");
    end

    state_t                 state;
    state_t                 nxt;
    state_t                 rel_target;
    state_t                 after_wr;
    logic [3:0]             turn_cnt;
    logic                   turn_done;
    logic                   rehold;
    logic                   sel_jtag;
    logic                   hlda;
    logic                   stall;
    logic [JTAG_ADDR_W-1:0] lat_addr;
    logic [JTAG_DATA_W-1:0] lat_data;
    logic [JTAG_DATA_W-1:0] rdata;
    logic [JTAG_ADDR_W-1:0] jtag_addr;

    logic wr_edge, pending, overrun, busy, done, we_n, oe;
    logic start, capture_en;

    assign start      = (state == S_GRANT) && (wr_edge || pending);
    assign capture_en = (state == S_WR) || (state == S_REC) || (state == S_WAIT);
    assign turn_done  = (turn_cnt >= TURN_CNT);

    jtag_wr_strobe_gen #(.WE_CYCLES(WE_CYCLES)) u_wr (
        .clk24      (clk24),
        .reset      (reset),
        .wr_n       (bus.iJTAG_WR_N),
        .capture_en (capture_en),
        .start      (start),
        .wr_edge    (wr_edge),
        .pending    (pending),
        .overrun    (overrun),
        .busy       (busy),
        .done       (done),
        .we_n       (we_n),
        .oe         (oe)
    );

    // after a write (and recovery) a queued write or a held bus keeps the grant
    always_comb begin
        rel_target = (TURN_CYCLES == 0) ? S_IDLE : S_REL;
        after_wr   = (pending || wr_edge || bus.iHOLD) ? S_GRANT : rel_target;
        nxt        = state;
        case (state)
            S_IDLE:  if (bus.iHOLD) nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.iHOLD)         nxt = S_IDLE;
                else if (bus.iCPU_IDLE) nxt = S_GRANT;
            end
            S_GRANT: begin
                if (start)           nxt = S_WR;
                else if (!bus.iHOLD) nxt = rel_target;
            end
            S_WR:    if (done) nxt = (TURN_CYCLES == 0) ? after_wr : S_REC;
            S_REC:   if (turn_done) nxt = after_wr;
            S_REL:   if (turn_done) nxt = (rehold || bus.iHOLD) ? S_WAIT : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hlda     <= 1'b0;
            stall    <= 1'b0;
            sel_jtag <= 1'b0;
            turn_cnt <= 4'd0;
            rehold   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            rdata    <= '0;
        end else begin
            state    <= nxt;
            hlda     <= (nxt == S_GRANT) || (nxt == S_WR) || (nxt == S_REC);
            stall    <= (nxt != S_IDLE);
            sel_jtag <= (nxt == S_GRANT) || (nxt == S_WR) || (nxt == S_REC) || (nxt == S_REL);
            rehold   <= (state == S_REL) && (nxt == S_REL) && (rehold || bus.iHOLD);

            if ((nxt == S_REC || nxt == S_REL) && nxt != state) begin
                turn_cnt <= 4'd1;
            end else if (state == S_REC || state == S_REL) begin
                if (!turn_done) turn_cnt <= sat_inc(turn_cnt);
            end else begin
                turn_cnt <= 4'd0;
            end

            if (state == S_GRANT) rdata <= bus.iSRAM_DQ_IN;

            if (start) begin
                lat_addr <= bus.iJTAG_ADDR;
                lat_data <= bus.iJTAG_DATA;
            end
        end
    end

    assign jtag_addr = busy ? lat_addr : bus.iJTAG_ADDR;

    assign bus.oHLDA        = hlda;
    assign bus.oCPU_STALL   = stall;
    assign bus.oJTAG_RDATA  = rdata;
    assign bus.oSRAM_ADDR   = sel_jtag ? jtag_addr : bus.iCPU_ADDR;
    assign bus.oSRAM_DQ_OUT = sel_jtag ? lat_data  : bus.iCPU_DATA;
    // reset gates the strobes directly so the SRAM is released without waiting for a clock
    assign bus.oSRAM_WE_N   = reset | (sel_jtag ? we_n : bus.iCPU_WR_N);
    assign bus.oSRAM_DQ_OE  = ~reset & (sel_jtag ? oe : ~bus.iCPU_WR_N);

endmodule

// File: tb/tb_jtag_sram_arbiter.sv
// tb/tb_jtag_sram_arbiter.sv - directed self-checking bench for jtag_sram_arbiter
module tb_jtag_sram_arbiter;
    import jtag_pkg::*;

    localparam logic [17:0] CPU_A = 18'h2AAAA;
    localparam logic [15:0] CPU_D = 16'h5555;

    logic clk24 = 1'b0;
    logic reset;
    int   n_run   = 0;
    int   n_fail  = 0;
    int   we_falls = 0;
    int   base;

    jtag_sram_arbiter_if bus();

    jtag_sram_arbiter #(.WE_CYCLES(2), .TURN_CYCLES(1)) dut (
        .clk24 (clk24),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk24 = ~clk24;

    always @(negedge bus.oSRAM_WE_N) we_falls++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic hlda, input logic stall,
                             input logic we_n, input logic oe);
        check({tag, ".hlda"},  32'(bus.oHLDA),       32'(hlda));
        check({tag, ".stall"}, 32'(bus.oCPU_STALL),  32'(stall));
        check({tag, ".we_n"},  32'(bus.oSRAM_WE_N),  32'(we_n));
        check({tag, ".oe"},    32'(bus.oSRAM_DQ_OE), 32'(oe));
    endtask

    task automatic step();
        @(posedge clk24);
        #1;
        check("hlda_implies_stall", 32'(bus.oHLDA & ~bus.oCPU_STALL), 32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.iHOLD       = 1'b0;
        bus.iCPU_IDLE   = 1'b0;
        bus.iJTAG_ADDR  = '0;
        bus.iJTAG_DATA  = '0;
        bus.iJTAG_WR_N  = 1'b1;
        bus.iCPU_ADDR   = CPU_A;
        bus.iCPU_DATA   = CPU_D;
        bus.iCPU_WR_N   = 1'b1;
        bus.iSRAM_DQ_IN = 16'hC0DE;
        #1;
        check_bus("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        check("rst.rdata", 32'(bus.oJTAG_RDATA), 32'd0);
        check("rst.state", 32'(dut.state), 32'(S_IDLE));
        repeat (2) @(posedge clk24);
        #1 reset = 1'b0;
        step();
        check("idle.addr", 32'(bus.oSRAM_ADDR), 32'(CPU_A));
        check("idle.dq",   32'(bus.oSRAM_DQ_OUT), 32'(CPU_D));

        // hold request waits for the CPU idle point
        bus.iHOLD      = 1'b1;
        bus.iJTAG_ADDR = 18'h01234;
        step();
        check_bus("wait", 1'b0, 1'b1, 1'b1, 1'b0);
        check("wait.addr", 32'(bus.oSRAM_ADDR), 32'(CPU_A));
        for (int i = 0; i < 4; i++) begin
            step();
            check("wait_n.hlda", 32'(bus.oHLDA), 32'd0);
        end
        bus.iCPU_IDLE = 1'b1;
        step();
        bus.iCPU_IDLE = 1'b0;
        check_bus("grant", 1'b1, 1'b1, 1'b1, 1'b0);
        check("grant.addr",  32'(bus.oSRAM_ADDR), 32'h01234);
        check("grant.state", 32'(dut.state), 32'(S_GRANT));
        bus.iSRAM_DQ_IN = 16'h1357;
        step();
        check("grant.rdata", 32'(bus.oJTAG_RDATA), 32'h1357);

        // single write: WE low 2 cycles, OE 3 cycles, 1 recovery cycle
        base           = we_falls;
        bus.iJTAG_DATA = 16'hBEEF;
        bus.iJTAG_WR_N = 1'b0;
        step();
        bus.iJTAG_WR_N = 1'b1;
        bus.iJTAG_ADDR = 18'h3FFFF;
        #1;
        check_bus("wr1", 1'b1, 1'b1, 1'b0, 1'b1);
        check("wr1.dq",   32'(bus.oSRAM_DQ_OUT), 32'hBEEF);
        check("wr1.addr", 32'(bus.oSRAM_ADDR), 32'h01234);
        step();
        check_bus("wr2", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_bus("wr_hold", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check_bus("wr_rec", 1'b1, 1'b1, 1'b1, 1'b0);
        check("wr_rec.state", 32'(dut.state), 32'(S_REC));
        step();
        check("wr_done.state", 32'(dut.state), 32'(S_GRANT));
        check("wr.count", 32'(we_falls - base), 32'd1);

        // hold dropped in the first WE cycle
        base           = we_falls;
        bus.iJTAG_ADDR = 18'h00042;
        bus.iJTAG_DATA = 16'hA5A5;
        bus.iJTAG_WR_N = 1'b0;
        step();
        bus.iJTAG_WR_N = 1'b1;
        bus.iHOLD      = 1'b0;
        #1;
        check_bus("drop_we1", 1'b1, 1'b1, 1'b0, 1'b1);
        check("drop_we1.dq", 32'(bus.oSRAM_DQ_OUT), 32'hA5A5);
        step();
        check_bus("drop_we2", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_bus("drop_hold", 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check_bus("drop_rec", 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check_bus("drop_rel", 1'b0, 1'b1, 1'b1, 1'b0);
        check("drop_rel.addr", 32'(bus.oSRAM_ADDR), 32'h00042);
        step();
        check_bus("drop_idle", 1'b0, 1'b0, 1'b1, 1'b0);
        check("drop_idle.addr", 32'(bus.oSRAM_ADDR), 32'(CPU_A));
        check("drop.count", 32'(we_falls - base), 32'd1);

        // back-to-back edges: second pends, third overruns
        bus.iHOLD     = 1'b1;
        bus.iCPU_IDLE = 1'b1;
        step();
        step();
        bus.iCPU_IDLE = 1'b0;
        check("ovr.grant", 32'(dut.state), 32'(S_GRANT));
        check("ovr.pre",   32'(dut.u_wr.overrun), 32'd0);
        base           = we_falls;
        bus.iJTAG_ADDR = 18'h00100;
        bus.iJTAG_DATA = 16'h1111;
        for (int i = 0; i < 6; i++) begin
            bus.iJTAG_WR_N = 1'(i % 2);
            step();
        end
        check("ovr.bit",    32'(dut.u_wr.overrun), 32'd1);
        check("ovr.state2", 32'(dut.state), 32'(S_WR));
        repeat (6) step();
        check("ovr.count",   32'(we_falls - base), 32'd2);
        check("ovr.pending", 32'(dut.u_wr.pending), 32'd0);
        check("ovr.end",     32'(dut.state), 32'(S_GRANT));
        bus.iHOLD = 1'b0;
        repeat (3) step();
        check("ovr.idle", 32'(dut.state), 32'(S_IDLE));

        // short hold without CPU idle never acknowledges
        bus.iHOLD = 1'b1;
        step();
        check_bus("short1", 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        check("short2.hlda", 32'(bus.oHLDA), 32'd0);
        bus.iHOLD = 1'b0;
        step();
        check_bus("short_end", 1'b0, 1'b0, 1'b1, 1'b0);
        check("short_end.state", 32'(dut.state), 32'(S_IDLE));
        bus.iCPU_WR_N = 1'b0;
        #1;
        check("cpu_wr.we_n", 32'(bus.oSRAM_WE_N), 32'd0);
        check("cpu_wr.oe",   32'(bus.oSRAM_DQ_OE), 32'd1);
        check("cpu_wr.dq",   32'(bus.oSRAM_DQ_OUT), 32'(CPU_D));
        bus.iCPU_WR_N = 1'b1;
        #1;
        check("cpu_rd.we_n", 32'(bus.oSRAM_WE_N), 32'd1);

        // asynchronous reset in the middle of a write
        bus.iHOLD     = 1'b1;
        bus.iCPU_IDLE = 1'b1;
        step();
        step();
        bus.iCPU_IDLE  = 1'b0;
        bus.iJTAG_WR_N = 1'b0;
        step();
        bus.iJTAG_WR_N = 1'b1;
        bus.iHOLD      = 1'b0;
        #1;
        check("rstw.pre_we_n", 32'(bus.oSRAM_WE_N), 32'd0);
        #1 reset = 1'b1;
        #1;
        check_bus("rstw.async", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk24);
        #1 reset = 1'b0;
        step();
        check_bus("rstw.after", 1'b0, 1'b0, 1'b1, 1'b0);
        check("rstw.state",   32'(dut.state), 32'(S_IDLE));
        check("rstw.rdata",   32'(bus.oJTAG_RDATA), 32'd0);
        check("rstw.overrun", 32'(dut.u_wr.overrun), 32'd0);
        check("rstw.pending", 32'(dut.u_wr.pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
